// File: rtl/spi_shift_out.sv
// SPI mode-0 transmit engine: loads a WIDTH-bit word and shifts it out MSB first
// with a CLK-derived sclk, active-low chip select and a CLK-domain sclk_rise strobe.
module spi_shift_out #(
    parameter int WIDTH   = 64,
    parameter int CLK_DIV = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic             sclk_rise
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [BW-1:0]    r_bit, w_bit;
    logic [WIDTH-1:0] r_sh, w_sh;
    logic             r_ready, w_ready;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_sclk, w_sclk;
    logic             r_mosi, w_mosi;
    logic             r_cs_n, w_cs_n;
    logic             r_rise, w_rise;
    logic             w_phase_end;

    assign w_phase_end = (r_cnt == CNT_LAST);

    // Outputs are computed for the next state here and registered below,
    // so every output changes together with the state it belongs to.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_sh    = r_sh;
        w_ready = r_ready;
        w_done  = 1'b0;
        w_sclk  = 1'b0;
        w_mosi  = r_mosi;
        w_cs_n  = r_cs_n;
        w_rise  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cs_n  = 1'b1;
                w_mosi  = 1'b0;
                w_ready = 1'b1;
                if (load) begin
                    w_state = S_SETUP;
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_sh    = d_in;
                    w_mosi  = d_in[WIDTH-1];
                    w_cs_n  = 1'b0;
                    w_ready = 1'b0;
                end
            end
            S_SETUP, S_LOW: begin
                if (w_phase_end) begin
                    w_state = S_HIGH;
                    w_cnt   = '0;
                    w_sclk  = 1'b1;
                    w_rise  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_cnt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state = S_HOLD;
                    end else begin
                        // Next bit is presented on the falling edge of sclk.
                        w_state = S_LOW;
                        w_sh    = {r_sh[WIDTH-2:0], 1'b0};
                        w_mosi  = r_sh[WIDTH-2];
                        w_bit   = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt  = r_cnt + 1'b1;
                    w_sclk = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_cs_n  = 1'b1;
                    w_mosi  = 1'b0;
                    w_done  = 1'b1;
                    w_ready = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_cs_n  = 1'b1;
                w_mosi  = 1'b0;
                w_ready = 1'b1;
            end
        endcase

        w_busy = ~w_ready;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_sh    <= w_sh;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
            r_cs_n  <= w_cs_n;
            r_rise  <= w_rise;
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign cs_n      = r_cs_n;
    assign sclk_rise = r_rise;

endmodule

// File: doc/spi_shift_out.md
Name: spi_shift_out

Overview:
Parallel-in, serial-out SPI transmit engine for the ok_spi path. It accepts a WIDTH-bit word from the host-side logic and emits it MSB first on mosi in SPI mode 0 (CPOL=0, CPHA=0). It generates sclk from CLK and frames the word with an active-low chip select. It is the transmit counterpart of the 64-bit shift-in receiver. A one-cycle sclk_rise strobe lets a CLK-domain receiver's enable sample each bit directly, for loopback.

Parameters:
WIDTH, 64, bits per transaction (must be >= 2)
CLK_DIV, 4, CLK cycles per sclk half-period (must be >= 1)

Ports:
CLK  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
d_in  in  WIDTH  word to transmit; sampled only on an accepted load
load  in  1  start request; accepted when ready=1
ready  out  1  engine idle and able to accept load
busy  out  1  transaction in progress (equals ~ready)
done  out  1  one-CLK pulse when the transaction completes
sclk  out  1  SPI clock; idles low
mosi  out  1  serial data, MSB first
cs_n  out  1  chip select, active low
sclk_rise  out  1  one-CLK pulse in the cycle sclk goes 0->1

Behaviour:
- States:
  - IDLE: ready=1.
  - SETUP: cs_n low, first bit on mosi, sclk low for CLK_DIV cycles.
  - HIGH: sclk high for CLK_DIV cycles.
  - LOW: sclk low for CLK_DIV cycles.
  - HOLD: sclk low, cs_n still low, for CLK_DIV cycles.
- Registers: a half-period counter (0..CLK_DIV-1), a bit counter (0..WIDTH-1), and a WIDTH-bit shift register.
- All outputs are registered.
- Reset values: ready=1, busy=0, done=0, sclk=0, mosi=0, cs_n=1, sclk_rise=0. Counters and the shift register clear to 0.
- Accept: load=1 in IDLE at edge E0. Latch d_in and go to SETUP. From E0+1: cs_n=0, mosi=d_in[WIDTH-1], busy=1, ready=0.
- SETUP -> HIGH after CLK_DIV cycles. sclk=1 and sclk_rise=1 in the first HIGH cycle. The receiver samples here.
- HIGH -> LOW after CLK_DIV cycles. On entry to LOW, sclk=0, shift left by one, mosi=next bit, bit counter +1.
- LOW -> HIGH after CLK_DIV cycles, while bits remain.
- After the WIDTH-th high phase, go to HOLD instead of LOW. sclk=0 and mosi holds its last value.
- HOLD -> IDLE after CLK_DIV cycles. In the first IDLE cycle: cs_n=1, done=1 for exactly one cycle, ready=1, mosi=0.
- Timing, relative to E0:
  - rising edge k (k = 0..WIDTH-1) at cycle 1+(2k+1)*CLK_DIV
  - cs_n low for 2*WIDTH*CLK_DIV + CLK_DIV cycles
  - done at cycle 1+(2*WIDTH+1)*CLK_DIV
- mosi changes only while sclk is low. It is stable for CLK_DIV cycles before and through each high phase.
- load while busy=1: ignored. No queuing, and the transaction in flight is unaffected.
- load in the done cycle (IDLE, ready=1): accepted. cs_n goes low again on the next cycle, giving a minimum 1-cycle cs_n high gap.
- d_in changes after acceptance: no effect on the transaction in flight.
- rst at any time, including mid-transaction: next edge returns to IDLE with reset output values. No done pulse is generated for the aborted word.
- CLK_DIV=1: sclk period is 2 CLK cycles. The same state sequence applies, with each phase lasting one cycle.

Test Plan:
1. WIDTH=64, CLK_DIV=4, load 64'hA5A5_0000_FFFF_1234 -> the 64 bits sampled on sclk_rise reassemble to 64'hA5A5_0000_FFFF_1234. cs_n low for 516 cycles. done exactly once, at cycle 517 after acceptance.
2. WIDTH=8, CLK_DIV=1, load 8'h81 -> mosi at the 8 rising edges reads 1,0,0,0,0,0,0,1. Rises at cycles 2,4,...,16. done at cycle 18. sclk stays low in idle.
3. Loopback: mosi drives a 64-bit CLK-domain shift-in receiver's data input, sclk_rise drives its enable. Load 64'hDEAD_BEEF_0123_4567 -> receiver holds 64'hDEAD_BEEF_0123_4567 at done.
4. Pulse load again at cycle 50 of transaction 1 with different d_in -> ignored. Transmitted word unchanged, exactly one done.
5. Assert rst at cycle 100 of a 64-bit transfer -> next cycle cs_n=1, sclk=0, mosi=0, ready=1, no done. A following load of 64'h1 transmits correctly.
6. Hold load=1 continuously with WIDTH=8, CLK_DIV=2 -> back-to-back transfers. cs_n high for exactly 1 cycle between frames, one done per frame.
